scnn_mult_array: RTL and testbench

//  F x I Cartesian-product multiplier array of the SCNN processing element (PE).
//  - Each cycle it takes F compressed non-zero weights and I compressed non-zero activations.
//  - It forms all F*I pairwise products.
//  - The products feed the PE's coordinate/scatter-accumulate logic.
//  - Products are registered: one-cycle latency, valid-qualified.

---
 rtl/scnn_pkg.sv | 9 +
 rtl/scnn_mult_cell.sv | 16 +
 rtl/scnn_mult_array.sv | 44 ++++
 tb/tb_scnn_mult_array.sv | 106 ++++++++++
 4 files changed

// File: rtl/scnn_pkg.sv
// scnn_pkg: shared widths, array dimensions and operand/product types for the SCNN PE
package scnn_pkg;
  localparam int SCNN_DATA_W = 16;
  localparam int SCNN_PROD_W = 32;
  localparam int SCNN_F = 4;
  localparam int SCNN_I = 4;
  typedef logic signed [SCNN_DATA_W-1:0] data_t;
  typedef logic signed [SCNN_PROD_W-1:0] prod_t;
endpackage

// File: rtl/scnn_mult_cell.sv
// scnn_mult_cell: combinational signed a*b, full-precision product sign-extended to PROD_W
module scnn_mult_cell
  import scnn_pkg::*;
#(
  parameter int DATA_W = SCNN_DATA_W,
  parameter int PROD_W = SCNN_PROD_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);
  logic signed [PROD_W-1:0] a_x, b_x;
  assign a_x = PROD_W'($signed(a));
  assign b_x = PROD_W'($signed(b));
  assign p = a_x * b_x;
endmodule

// File: rtl/scnn_mult_array.sv
// scnn_mult_array: F x I registered signed Cartesian-product multiplier, ops[NUM_IP*k+n] = wts[k]*ips[n], 1-cycle latency
module scnn_mult_array
  import scnn_pkg::*;
#(
  parameter int NUM_WT = SCNN_F,
  parameter int NUM_IP = SCNN_I,
  parameter int DATA_W = SCNN_DATA_W,
  parameter int PROD_W = SCNN_PROD_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [NUM_WT-1:0][DATA_W-1:0]          wts_to_mult,
  input  logic [NUM_IP-1:0][DATA_W-1:0]          ips_to_mult,
  output logic                                   out_valid,
  output logic [NUM_WT*NUM_IP-1:0][PROD_W-1:0]   ops_from_mult
);
  logic [NUM_WT*NUM_IP-1:0][PROD_W-1:0] prod, ops_d, ops_q;
  logic out_valid_d, out_valid_q;
  for (genvar k = 0; k < NUM_WT; k++) begin : g_wt
    for (genvar n = 0; n < NUM_IP; n++) begin : g_ip
      scnn_mult_cell #(.DATA_W(DATA_W), .PROD_W(PROD_W)) u_cell (
        .a(wts_to_mult[k]),
        .b(ips_to_mult[n]),
        .p(prod[NUM_IP*k+n])
      );
    end
  end
  always_comb begin
    ops_d = in_valid ? prod : ops_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ops_q <= ops_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign ops_from_mult = ops_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_scnn_mult_array.sv
// tb_scnn_mult_array: scoreboard bench for scnn_mult_array against an independent product model
module tb_scnn_mult_array;
  logic clk, rst, in_valid, out_valid;
  logic [3:0][15:0] wts, ips;
  logic [15:0][31:0] ops;
  typedef struct {
    logic v;
    logic [15:0][31:0] o;
  } exp_t;
  exp_t sb[$];
  logic [15:0][31:0] mdl_ops;
  logic mdl_v;
  int n_cmp, n_bad;
  scnn_mult_array dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .wts_to_mult(wts),
    .ips_to_mult(ips),
    .out_valid(out_valid),
    .ops_from_mult(ops)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0][15:0] rnd();
    return {$urandom(), $urandom()};
  endfunction
  task automatic step(input logic r, input logic v, input logic [3:0][15:0] w, input logic [3:0][15:0] ip);
    exp_t e;
    rst = r;
    in_valid = v;
    wts = w;
    ips = ip;
    if (r) begin
      mdl_ops = '0;
      mdl_v = 1'b0;
    end else begin
      mdl_v = v;
      if (v)
        for (int k = 0; k < 4; k++)
          for (int n = 0; n < 4; n++)
            mdl_ops[4*k+n] = int'($signed(w[k])) * int'($signed(ip[n]));
    end
    sb.push_back('{mdl_v, mdl_ops});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("vld", {31'd0, out_valid}, {31'd0, e.v});
      for (int j = 0; j < 16; j++) chk($sformatf("ops%0d", j), ops[j], e.o[j]);
    end
  endtask
  initial begin
    logic [3:0][15:0] a_w, a_i;
    n_cmp = 0;
    n_bad = 0;
    mdl_ops = '0;
    mdl_v = 1'b0;
    rst = 1'b1;
    in_valid = 1'b1;
    wts = '0;
    ips = '0;
    step(1'b1, 1'b1, rnd(), rnd());
    step(1'b1, 1'b1, rnd(), rnd());
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_ops15", ops[15], 32'd0);
    step(1'b0, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5});
    chk("map0", ops[0], 32'd5);
    chk("map1", ops[1], 32'd6);
    chk("map4", ops[4], 32'd10);
    chk("map15", ops[15], 32'd32);
    chk("map_vld", {31'd0, out_valid}, 32'd1);
    step(1'b0, 1'b1, {16'd0, 16'd0, 16'hFFFF, 16'h8000}, {16'd0, 16'd7, 16'd0, 16'h8000});
    chk("ext0", ops[0], 32'h4000_0000);
    chk("ext6", ops[6], 32'hFFFF_FFF9);
    chk("ext_zero", ops[15], 32'd0);
    a_w = rnd();
    a_i = rnd();
    step(1'b0, 1'b1, a_w, a_i);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, rnd(), rnd());
    chk("hold12", ops[12], 32'(int'($signed(a_w[3])) * int'($signed(a_i[0]))));
    chk("hold_vld", {31'd0, out_valid}, 32'd0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1, rnd(), rnd());
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, rnd(), rnd());
    step(1'b1, 1'b1, rnd(), rnd());
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ops3", ops[3], 32'd0);
    step(1'b0, 1'b1, {16'd9, 16'hFFFE, 16'd3, 16'd2}, {16'd1, 16'd2, 16'd3, 16'hFFFD});
    chk("post_rst0", ops[0], 32'hFFFF_FFFA);
    chk("post_rst9", ops[9], 32'hFFFF_FFFA);
    chk("post_rst15", ops[15], 32'd9);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, rnd(), rnd());
    step(1'b0, 1'b0, rnd(), rnd());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
